// File: rtl/seg7_bcd_scan.sv
// 8-bit binary to 3-digit BCD (sequential double-dabble) with a multiplexed common-anode 7-segment driver.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero hundreds/tens digits.
module seg7_bcd_scan #(
    parameter int SCAN_DIV = 50000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] VALUE_i,
    input  logic       LOAD_i,
    output logic       BUSY_o,
    output logic       DONE_o,
    output logic [6:0] SEG_o,
    output logic [2:0] AN_o
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

    state_t        state_q;
    logic [7:0]    bin_q;
    logic [11:0]   bcd_q;
    logic [11:0]   disp_q;
    logic [3:0]    step_q;
    logic          busy_q;
    logic          done_q;
    logic [11:0]   bcdAdj_d;
    logic [CW-1:0] scanCnt_q;
    logic [1:0]    digitIdx_q;
    logic [3:0]    digit;
    logic          blank;

    always_comb begin
        bcdAdj_d = bcd_q;
        for (int i = 0; i < 3; i++) begin
            if (bcd_q[i*4 +: 4] >= 4'd5) begin
                bcdAdj_d[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            disp_q  <= '0;
            step_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (LOAD_i) begin
                        bin_q   <= VALUE_i;
                        bcd_q   <= '0;
                        step_q  <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    {bcd_q, bin_q} <= {bcdAdj_d, bin_q} << 1;
                    step_q         <= step_q + 4'd1;
                    if (step_q == 4'd7) begin
                        done_q  <= 1'b1;
                        state_q <= FINISH;
                    end
                end
                FINISH: begin
                    disp_q  <= bcd_q;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Scan position runs freely; display updates never disturb it.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            scanCnt_q  <= '0;
            digitIdx_q <= '0;
        end else if (scanCnt_q == SCAN_LAST) begin
            scanCnt_q  <= '0;
            digitIdx_q <= (digitIdx_q == 2'd2) ? 2'd0 : digitIdx_q + 2'd1;
        end else begin
            scanCnt_q <= scanCnt_q + 1'b1;
        end
    end

    always_comb begin
        digit = disp_q[3:0];
        blank = 1'b0;
        AN_o  = 3'b110;
        case (digitIdx_q)
            2'd1: begin
                digit = disp_q[7:4];
                AN_o  = 3'b101;
`ifdef LEADING_ZERO_BLANK_EN
                blank = (disp_q[11:4] == 8'd0);
`endif
            end
            2'd2: begin
                digit = disp_q[11:8];
                AN_o  = 3'b011;
`ifdef LEADING_ZERO_BLANK_EN
                blank = (disp_q[11:8] == 4'd0);
`endif
            end
            default: ;
        endcase
    end

    always_comb begin
        SEG_o = 7'b1111111;
        if (!blank) begin
            case (digit)
                4'd0: SEG_o = 7'b1000000;
                4'd1: SEG_o = 7'b1111001;
                4'd2: SEG_o = 7'b0100100;
                4'd3: SEG_o = 7'b0110000;
                4'd4: SEG_o = 7'b0011001;
                4'd5: SEG_o = 7'b0010010;
                4'd6: SEG_o = 7'b0000010;
                4'd7: SEG_o = 7'b1111000;
                4'd8: SEG_o = 7'b0000000;
                4'd9: SEG_o = 7'b0010000;
                default: SEG_o = 7'b1111111;
            endcase
        end
    end

    assign BUSY_o = busy_q;
    assign DONE_o = done_q;

endmodule

// File: tb/tb_seg7_bcd_scan.sv
// Self-checking bench for seg7_bcd_scan against a decimal-arithmetic display model.
module tb_seg7_bcd_scan;

    localparam int DIV = 4;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [7:0] value = 8'd0;
    logic       load = 1'b0;
    logic       busy;
    logic       done;
    logic [6:0] seg;
    logic [2:0] an;

    int checks = 0;
    int failures = 0;

    logic [6:0] segTab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    seg7_bcd_scan #(.SCAN_DIV(DIV)) dut (
        .CLK    (CLK),
        .RST    (RST),
        .VALUE_i(value),
        .LOAD_i (load),
        .BUSY_o (busy),
        .DONE_o (done),
        .SEG_o  (seg),
        .AN_o   (an)
    );

    always #5 CLK = ~CLK;

    function automatic logic [6:0] expSeg(input int v, input int pos);
        int d;
        d = (pos == 0) ? v % 10 : (pos == 1) ? (v / 10) % 10 : v / 100;
`ifdef LEADING_ZERO_BLANK_EN
        if (pos == 2 && v < 100) return 7'b1111111;
        if (pos == 1 && v < 10) return 7'b1111111;
`endif
        return segTab[d];
    endfunction

    function automatic logic [2:0] expAn(input int pos);
        case (pos)
            0: return 3'b110;
            1: return 3'b101;
            default: return 3'b011;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Wait for each scan position in turn and compare its segments to the model.
    task automatic checkDigits(input int v);
        for (int pos = 0; pos < 3; pos++) begin
            bit found = 0;
            for (int k = 0; k < 20 && !found; k++) begin
                if (an === expAn(pos)) found = 1;
                else step();
            end
            checkOutput($sformatf("an_reach_%0d", pos), 32'(found), 32'd1);
            if (found) checkOutput($sformatf("seg_v%0d_p%0d", v, pos), 32'(seg), 32'(expSeg(v, pos)));
        end
    endtask

    task automatic applyStimulus(input int v);
        int k = 0;
        int doneAt = 0;
        int doneCnt = 0;
        value = 8'(v);
        load = 1'b1;
        step();
        load = 1'b0;
        while (busy === 1'b1 && k < 30) begin
            k++;
            if (done === 1'b1) begin
                doneCnt++;
                doneAt = k;
            end
            step();
        end
        checkOutput($sformatf("busy_len_v%0d", v), 32'(k), 32'd9);
        checkOutput($sformatf("done_at_v%0d", v), 32'(doneAt), 32'd9);
        checkOutput($sformatf("done_cnt_v%0d", v), 32'(doneCnt), 32'd1);
        checkDigits(v);
    endtask

    initial begin
        bit sawDone;
        int pos;
        #2;
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_an", 32'(an), 32'(3'b110));
        checkOutput("rst_seg", 32'(seg), 32'(7'b1000000));
        step();
        step();
        RST = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            step();
            checkOutput($sformatf("scan_an_%0d", k), 32'(an), 32'(expAn((k / DIV) % 3)));
            checkOutput($sformatf("scan_seg_%0d", k), 32'(seg), 32'(expSeg(0, (k / DIV) % 3)));
        end

        applyStimulus(255);
        applyStimulus(7);
        applyStimulus(100);
        applyStimulus(0);
        for (int n = 0; n < 8; n++) applyStimulus(int'($urandom_range(0, 255)));

        // LOAD held high; VALUE changes mid-conversion and must not affect the first result.
        $display("[TB] held LOAD 42 -> 99");
        value = 8'd42;
        load = 1'b1;
        for (int e = 0; e < 20; e++) begin
            step();
            if (e == 2) value = 8'd99;
            if (e == 10) load = 1'b0;
            checkOutput($sformatf("held_busy_E%0d", e), 32'(busy),
                        32'((e <= 8) || (e >= 10 && e <= 18)));
            checkOutput($sformatf("held_done_E%0d", e), 32'(done), 32'(e == 8 || e == 18));
            if (e == 9) begin
                pos = (an == 3'b110) ? 0 : (an == 3'b101) ? 1 : 2;
                checkOutput("held_first_seg", 32'(seg), 32'(expSeg(42, pos)));
            end
        end
        checkDigits(99);

        applyStimulus(123);
        $display("[TB] reset during conversion of 200");
        value = 8'd200;
        load = 1'b1;
        step();
        load = 1'b0;
        for (int k = 0; k < 4; k++) step();
        RST = 1'b0;
        #1;
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        checkOutput("midrst_done", 32'(done), 32'd0);
        checkOutput("midrst_an", 32'(an), 32'(3'b110));
        checkOutput("midrst_seg", 32'(seg), 32'(7'b1000000));
        step();
        RST = 1'b1;
        sawDone = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (done === 1'b1 || busy === 1'b1) sawDone = 1;
        end
        checkOutput("midrst_no_done", 32'(sawDone), 32'd0);
        checkDigits(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
